// File: rtl/lcd_pkg.sv
// Shared constants and FSM state type for the LCD text path.
// Font cell sizes, panel defaults and the text-walker state encoding.
package lcd_pkg;

  localparam int FONT16_W = 8;
  localparam int FONT16_H = 16;
  localparam int FONT12_W = 6;
  localparam int FONT12_H = 12;

  localparam logic [6:0] ASCII_LF = 7'h0A;

  localparam int PANEL_W = 240;
  localparam int PANEL_H = 320;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_CHK   = 3'd2,
    ST_ISSUE = 3'd3,
    ST_WAIT  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/lcd_text_ram.sv
// Text buffer: DEPTH x 7 simple dual-port RAM, one write port, registered read.
// Read data updates only on rd_en; a same-cycle write to the read address returns old data.
module lcd_text_ram #(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [6:0]    wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [6:0]    rd_data
);

  logic [6:0] mem_q [DEPTH];
  logic [6:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/lcd_text_ctrl.sv
// Walks the text buffer and hands one character at a time to the char-draw engine,
// tracking the pixel cursor by accumulation with wrap, newline and bottom truncation.
module lcd_text_ctrl
  import lcd_pkg::*;
#(
  parameter int MAX_CHARS = 32,
  parameter int FONT_SEL  = 1,
  parameter int SCREEN_W  = PANEL_W,
  parameter int SCREEN_H  = PANEL_H,
  parameter int ORIGIN_X  = 0,
  parameter int ORIGIN_Y  = 0
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst,
  input  logic                         init_done,
  input  logic                         wr_en,
  input  logic [$clog2(MAX_CHARS)-1:0] wr_addr,
  input  logic [6:0]                   wr_data,
  input  logic [$clog2(MAX_CHARS):0]   str_len,
  input  logic                         refresh_req,
  input  logic                         show_char_done,
  output logic                         en_size,
  output logic                         show_char_flag,
  output logic [6:0]                   ascii_num,
  output logic [8:0]                   start_x,
  output logic [8:0]                   start_y,
  output logic                         busy,
  output logic                         pass_done
);

  localparam int AW = $clog2(MAX_CHARS);
  localparam int FW = (FONT_SEL != 0) ? FONT16_W : FONT12_W;
  localparam int FH = (FONT_SEL != 0) ? FONT16_H : FONT12_H;

  localparam logic [9:0]  FW10   = 10'(FW);
  localparam logic [9:0]  FH10   = 10'(FH);
  localparam logic [9:0]  SW10   = 10'(SCREEN_W);
  localparam logic [9:0]  SH10   = 10'(SCREEN_H);
  localparam logic [9:0]  OX10   = 10'(ORIGIN_X);
  localparam logic [9:0]  OY10   = 10'(ORIGIN_Y);
  localparam logic [AW:0] MAXLEN = (AW+1)'(MAX_CHARS);

  state_e      state_q, state_d;
  logic [AW:0] idx_q, idx_d;
  logic [9:0]  cx_q, cx_d, cy_q, cy_d;
  logic        pend_q, pend_d;
  logic        init_q;
  logic [6:0]  ascii_q, ascii_d;
  logic [8:0]  sx_q, sx_d, sy_q, sy_d;

  logic [AW:0] eff_len;
  logic        trig;
  logic        rd_en;
  logic [6:0]  rd_data;

  assign eff_len = (str_len > MAXLEN) ? MAXLEN : str_len;
  assign trig    = init_done && (!init_q || refresh_req);
  assign rd_en   = (state_q == ST_RD) && (idx_q != eff_len);

  lcd_text_ram #(
    .DEPTH (MAX_CHARS),
    .AW    (AW)
  ) u_ram (
    .clk     (sys_clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (idx_q[AW-1:0]),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    pend_d  = pend_q;
    ascii_d = ascii_q;
    sx_d    = sx_q;
    sy_d    = sy_q;

    if (busy && trig) pend_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (trig) begin
          idx_d   = '0;
          cx_d    = OX10;
          cy_d    = OY10;
          pend_d  = 1'b0;
          state_d = ST_RD;
        end
      end
      ST_RD: state_d = (idx_q == eff_len) ? ST_DONE : ST_CHK;
      ST_CHK: begin
        // Wrap leaves us in CHK so the row check sees the new cursor next cycle.
        if (rd_data == ASCII_LF) begin
          cx_d    = OX10;
          cy_d    = cy_q + FH10;
          idx_d   = idx_q + (AW+1)'(1);
          state_d = ST_RD;
        end else if (cx_q + FW10 > SW10) begin
          cx_d = OX10;
          cy_d = cy_q + FH10;
        end else if (cy_q + FH10 > SH10) begin
          state_d = ST_DONE;
        end else begin
          ascii_d = rd_data;
          sx_d    = cx_q[8:0];
          sy_d    = cy_q[8:0];
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (show_char_done) begin
          cx_d    = cx_q + FW10;
          idx_d   = idx_q + (AW+1)'(1);
          state_d = ST_RD;
        end
      end
      ST_DONE: begin
        if (pend_q || trig) begin
          idx_d   = '0;
          cx_d    = OX10;
          cy_d    = OY10;
          pend_d  = 1'b0;
          state_d = ST_RD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Losing the panel abandons the pass outright: no pass_done, nothing queued.
    if (!init_done) begin
      state_d = ST_IDLE;
      pend_d  = 1'b0;
      ascii_d = '0;
      sx_d    = '0;
      sy_d    = '0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      pend_q  <= 1'b0;
      init_q  <= 1'b0;
      ascii_q <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      pend_q  <= pend_d;
      init_q  <= init_done;
      ascii_q <= ascii_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
    end
  end

  assign en_size        = (FONT_SEL != 0);
  assign show_char_flag = (state_q == ST_ISSUE);
  assign pass_done      = (state_q == ST_DONE);
  assign busy           = (state_q == ST_RD) || (state_q == ST_CHK) ||
                          (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign ascii_num      = ascii_q;
  assign start_x        = sx_q;
  assign start_y        = sy_q;

endmodule
